// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_pkg
// Purpose  : Shared definitions for the instruction-cycle controller and the
//            blocks that display or react to its phase code.
// Contents : c_PC_W_DEFAULT - default program-counter / jump-address width
//            c_PHASE_W      - width of the phase code
//            c_BEAT_W       - width of the execute beat counter
//            phase_e        - phase / state code (IDLE..HALTED)
// Revision : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    localparam int c_PC_W_DEFAULT = 8;
    localparam int c_PHASE_W      = 3;
    // Holds EXEC_CYCLES-1 for the legal range EXEC_CYCLES = 1..7.
    localparam int c_BEAT_W       = 3;

    typedef enum logic [c_PHASE_W-1:0] {
        PH_IDLE   = 3'd0,
        PH_F_ADDR = 3'd1,
        PH_F_DATA = 3'd2,
        PH_DECODE = 3'd3,
        PH_EXEC   = 3'd4,
        PH_HALTED = 3'd5
    } phase_e;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_edge_det
// Purpose  : 1-bit rising-edge detector. The previous input value is held in
//            a flop; the pulse is high while the input is high and the stored
//            value is low, so the clock edge that samples it sees one pulse.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset (clears the history flop)
//            i_d    - level input
//            o_rise - rising-edge pulse
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev_q;
    logic w_prev_d;

    always_comb begin
        w_prev_d = i_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_q <= 1'b0;
        end else begin
            r_prev_q <= w_prev_d;
        end
    end

    assign o_rise = i_d & ~r_prev_q;

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Instruction-cycle controller. Sequences fetch (address, data),
//            decode and a multi-beat execute phase; drives PC increment, PC
//            parallel load for jumps, memory read and IR load. Supports run,
//            stop, single-step and halt.
// Params   : PC_W        - PC / jump-address width
//            EXEC_CYCLES - execute beats per instruction (1..7)
// Ports    : clk, CLEARn (async active-low reset)
//            START (edge), STOP, STEP, HALT_REQ, JMP_REQ, JMP_ADDR
//            PC_INC, PC_LD, PC_LD_ADDR, MEM_RD, IR_LD, RUNNING, PHASE
// Options  : PC_SEQ_BREAKPOINT_EN adds PC_VAL, BP_ADDR, BP_EN inputs and the
//            sticky BP_HIT output.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W        = c_PC_W_DEFAULT,
    parameter int EXEC_CYCLES = 2
) (
    input  logic            clk,
    input  logic            CLEARn,
    input  logic            START,
    input  logic            STOP,
    input  logic            STEP,
    input  logic            HALT_REQ,
    input  logic            JMP_REQ,
    input  logic [PC_W-1:0] JMP_ADDR,
    output logic            PC_INC,
    output logic            PC_LD,
    output logic [PC_W-1:0] PC_LD_ADDR,
    output logic            MEM_RD,
    output logic            IR_LD,
    output logic            RUNNING,
    output logic [2:0]      PHASE
`ifdef PC_SEQ_BREAKPOINT_EN
    ,
    input  logic [PC_W-1:0] PC_VAL,
    input  logic [PC_W-1:0] BP_ADDR,
    input  logic            BP_EN,
    output logic            BP_HIT
`endif
);

    localparam logic [c_BEAT_W-1:0] c_BEAT_LOAD = c_BEAT_W'(EXEC_CYCLES - 1);

    phase_e              r_state_q, w_state_d;
    logic [c_BEAT_W-1:0] r_beat_q,  w_beat_d;
    logic                r_stop_pend_q, w_stop_pend_d;
    logic                w_start_edge;
    logic                w_pc_ld;

    pc_sequencer_edge_det u_start_edge (
        .clk    (clk),
        .rst_n  (CLEARn),
        .i_d    (START),
        .o_rise (w_start_edge)
    );

`ifdef PC_SEQ_BREAKPOINT_EN
    logic r_bp_hit_q, w_bp_hit_d;
    logic w_bp_match;
    assign w_bp_match = BP_EN && (PC_VAL == BP_ADDR);
`endif

    always_comb begin
        w_state_d     = r_state_q;
        w_beat_d      = r_beat_q;
        w_stop_pend_d = r_stop_pend_q;
        w_pc_ld       = 1'b0;
`ifdef PC_SEQ_BREAKPOINT_EN
        w_bp_hit_d    = r_bp_hit_q;
        if (w_start_edge) begin
            w_bp_hit_d = 1'b0;
        end
`endif

        case (r_state_q)
            PH_IDLE: begin
                // STOP wins over a simultaneous START edge.
                if (w_start_edge && !STOP) begin
                    w_state_d = PH_F_ADDR;
`ifdef PC_SEQ_BREAKPOINT_EN
                    // The edge that resumes after a hit skips the check once.
                    if (w_bp_match && !r_bp_hit_q) begin
                        w_state_d  = PH_IDLE;
                        w_bp_hit_d = 1'b1;
                    end
`endif
                end
            end
            PH_F_ADDR: w_state_d = PH_F_DATA;
            PH_F_DATA: w_state_d = PH_DECODE;
            PH_DECODE: begin
                w_beat_d  = c_BEAT_LOAD;
                w_state_d = PH_EXEC;
            end
            PH_EXEC: begin
                if (r_beat_q != '0) begin
                    w_beat_d = r_beat_q - 1'b1;
                end else if (HALT_REQ) begin
                    // Halt takes priority and suppresses any pending jump.
                    w_state_d = PH_HALTED;
                end else begin
                    w_pc_ld = JMP_REQ;
                    if (r_stop_pend_q || STEP) begin
                        w_state_d = PH_IDLE;
                    end else begin
                        w_state_d = PH_F_ADDR;
`ifdef PC_SEQ_BREAKPOINT_EN
                        if (w_bp_match) begin
                            w_state_d  = PH_IDLE;
                            w_bp_hit_d = 1'b1;
                        end
`endif
                    end
                end
            end
            PH_HALTED: w_state_d = PH_HALTED;
            default:   w_state_d = PH_IDLE;
        endcase

        // Pending stop is consumed when the sequencer comes to rest.
        if (w_state_d == PH_IDLE) begin
            w_stop_pend_d = 1'b0;
        end else if (STOP && (r_state_q != PH_IDLE) && (r_state_q != PH_HALTED)) begin
            w_stop_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge CLEARn) begin
        if (!CLEARn) begin
            r_state_q     <= PH_IDLE;
            r_beat_q      <= '0;
            r_stop_pend_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_beat_q      <= w_beat_d;
            r_stop_pend_q <= w_stop_pend_d;
        end
    end

`ifdef PC_SEQ_BREAKPOINT_EN
    always_ff @(posedge clk or negedge CLEARn) begin
        if (!CLEARn) begin
            r_bp_hit_q <= 1'b0;
        end else begin
            r_bp_hit_q <= w_bp_hit_d;
        end
    end
    assign BP_HIT = r_bp_hit_q;
`endif

    // Moore decodes of the registered state; PC_LD / PC_LD_ADDR are the only
    // outputs that follow the inputs within the cycle.
    assign PHASE      = r_state_q;
    assign MEM_RD     = (r_state_q == PH_F_ADDR) || (r_state_q == PH_F_DATA);
    assign IR_LD      = (r_state_q == PH_F_DATA);
    assign PC_INC     = (r_state_q == PH_F_DATA);
    assign RUNNING    = (r_state_q == PH_F_ADDR) || (r_state_q == PH_F_DATA) ||
                        (r_state_q == PH_DECODE) || (r_state_q == PH_EXEC);
    assign PC_LD      = w_pc_ld;
    assign PC_LD_ADDR = w_pc_ld ? JMP_ADDR : '0;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer. A position-in-instruction
//            reference model predicts every output each cycle; scenario
//            tasks add directed checks on top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int PC_W        = 8;
    localparam int EXEC_CYCLES = 2;
    localparam int INSTR_LEN   = 3 + EXEC_CYCLES;

    logic            clk = 1'b0;
    logic            CLEARn;
    logic            START, STOP, STEP, HALT_REQ, JMP_REQ;
    logic [PC_W-1:0] JMP_ADDR;
    logic            PC_INC, PC_LD, MEM_RD, IR_LD, RUNNING;
    logic [PC_W-1:0] PC_LD_ADDR;
    logic [2:0]      PHASE;

    int check_cnt = 0;
    int fail_cnt  = 0;

    // Model: mode 0 = idle, 1 = running, 2 = halted; pos = cycle within instr.
    int m_mode, m_pos;
    bit m_sp, m_prev;

    logic [15:0] o_v, e_v;

    pc_sequencer #(.PC_W(PC_W), .EXEC_CYCLES(EXEC_CYCLES)) dut (
        .clk        (clk),
        .CLEARn     (CLEARn),
        .START      (START),
        .STOP       (STOP),
        .STEP       (STEP),
        .HALT_REQ   (HALT_REQ),
        .JMP_REQ    (JMP_REQ),
        .JMP_ADDR   (JMP_ADDR),
        .PC_INC     (PC_INC),
        .PC_LD      (PC_LD),
        .PC_LD_ADDR (PC_LD_ADDR),
        .MEM_RD     (MEM_RD),
        .IR_LD      (IR_LD),
        .RUNNING    (RUNNING),
        .PHASE      (PHASE)
    );

    always #5 clk = ~clk;

    // Bit layout: [15:13] PHASE, [12] RUNNING, [11] MEM_RD, [10] IR_LD,
    // [9] PC_INC, [8] PC_LD, [7:0] PC_LD_ADDR
    function automatic logic [15:0] obs_vec();
        return {PHASE, RUNNING, MEM_RD, IR_LD, PC_INC, PC_LD, PC_LD_ADDR};
    endfunction

    function automatic logic [15:0] model_out();
        logic [2:0] ph;
        logic run, mr, ir, inc, ld;
        logic [7:0] a;
        ph = 3'd0; run = 1'b0; mr = 1'b0; ir = 1'b0; inc = 1'b0; ld = 1'b0; a = 8'h00;
        if (m_mode == 2) begin
            ph = 3'd5;
        end else if (m_mode == 1) begin
            run = 1'b1;
            ph  = (m_pos < 3) ? 3'(m_pos + 1) : 3'd4;
            mr  = (m_pos < 2);
            ir  = (m_pos == 1);
            inc = (m_pos == 1);
            ld  = (m_pos == INSTR_LEN - 1) && !HALT_REQ && JMP_REQ;
            a   = ld ? JMP_ADDR : 8'h00;
        end
        return {ph, run, mr, ir, inc, ld, a};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_sp = 1'b0; m_prev = 1'b0;
    endtask

    task automatic model_advance();
        bit e, sp_old;
        if (!CLEARn) begin
            model_reset();
            return;
        end
        sp_old = m_sp;
        e      = START && !m_prev;
        m_prev = START;
        case (m_mode)
            0: if (e && !STOP) begin m_mode = 1; m_pos = 0; end
            1: begin
                if (STOP) m_sp = 1'b1;
                if (m_pos == INSTR_LEN - 1) begin
                    if (HALT_REQ) m_mode = 2;
                    else if (sp_old || STEP) begin m_mode = 0; m_sp = 1'b0; end
                    else m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
            default: ;
        endcase
    endtask

    // One clock cycle: sample outputs after inputs settle, then clock.
    task automatic cyc(output logic [15:0] o, output logic [15:0] e);
        #1;
        e = model_out();
        o = obs_vec();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic do_clear();
        CLEARn = 1'b0;
        #2;
        CLEARn = 1'b1;
        model_reset();
    endtask

    task automatic idle_inputs();
        START = 1'b0; STOP = 1'b0; STEP = 1'b0; HALT_REQ = 1'b0; JMP_REQ = 1'b0; JMP_ADDR = 8'h00;
    endtask

    task automatic test_reset();
        idle_inputs();
        CLEARn  = 1'b0;
        JMP_REQ = 1'b1;
        JMP_ADDR = 8'hFF;
        @(posedge clk); #1;
        check_cnt++;
        if (obs_vec() !== 16'h0000) begin
            fail_cnt++;
            $display("FAIL reset_outputs got=%h want=%h", obs_vec(), 16'h0000);
        end
        CLEARn = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(o_v, e_v);
            check_cnt++;
            if (o_v !== e_v) begin fail_cnt++; $display("FAIL reset_idle got=%h want=%h", o_v, e_v); end
        end
        idle_inputs();
    endtask

    task automatic test_basic_run();
        int seq [5] = '{1, 2, 3, 4, 4};
        int inc_cnt = 0;
        do_clear();
        START = 1'b1;
        cyc(o_v, e_v);
        check_cnt++;
        if (o_v !== e_v) begin fail_cnt++; $display("FAIL basic_edge got=%h want=%h", o_v, e_v); end
        START = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc(o_v, e_v);
            check_cnt++;
            if (o_v !== e_v) begin fail_cnt++; $display("FAIL basic_model i=%0d got=%h want=%h", i, o_v, e_v); end
            check_cnt++;
            if (o_v[15:13] !== 3'(seq[i % 5])) begin
                fail_cnt++;
                $display("FAIL basic_phase i=%0d got=%0d want=%0d", i, o_v[15:13], seq[i % 5]);
            end
            if (o_v[9]) inc_cnt++;
        end
        check_cnt++;
        if (inc_cnt != 3) begin fail_cnt++; $display("FAIL basic_pc_inc_count got=%0d want=3", inc_cnt); end
    endtask

    task automatic test_jump();
        do_clear();
        START = 1'b1;
        cyc(o_v, e_v);
        START = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 4) begin JMP_REQ = 1'b1; JMP_ADDR = 8'($urandom); end
            if (k == 5) begin JMP_REQ = 1'b1; JMP_ADDR = 8'h40; end
            cyc(o_v, e_v);
            check_cnt++;
            if (o_v !== e_v) begin fail_cnt++; $display("FAIL jump_model k=%0d got=%h want=%h", k, o_v, e_v); end
            if (k == 5) begin
                check_cnt++;
                if ({o_v[9], o_v[8], o_v[7:0]} !== {1'b0, 1'b1, 8'h40}) begin
                    fail_cnt++;
                    $display("FAIL jump_strobe got=inc%b ld%b addr%h want=inc0 ld1 addr40", o_v[9], o_v[8], o_v[7:0]);
                end
            end
        end
        JMP_REQ = 1'b0;
        JMP_ADDR = 8'h77;
        cyc(o_v, e_v);
        check_cnt++;
        if (o_v[15:13] !== 3'd1 || o_v[7:0] !== 8'h00) begin
            fail_cnt++;
            $display("FAIL jump_next got=ph%0d addr%h want=ph1 addr00", o_v[15:13], o_v[7:0]);
        end
    endtask

    task automatic test_halt();
        bit ld_seen = 1'b0;
        do_clear();
        START = 1'b1;
        cyc(o_v, e_v);
        START = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) begin HALT_REQ = 1'b1; JMP_REQ = 1'b1; JMP_ADDR = 8'hA5; end
            cyc(o_v, e_v);
            check_cnt++;
            if (o_v !== e_v) begin fail_cnt++; $display("FAIL halt_model k=%0d got=%h want=%h", k, o_v, e_v); end
            if (o_v[8]) ld_seen = 1'b1;
        end
        HALT_REQ = 1'b0; JMP_REQ = 1'b0;
        for (int i = 0; i < 6; i++) begin
            START = i[0];
            cyc(o_v, e_v);
            if (o_v[8]) ld_seen = 1'b1;
            check_cnt++;
            if ({o_v[15:13], o_v[12]} !== {3'd5, 1'b0}) begin
                fail_cnt++;
                $display("FAIL halt_hold i=%0d got=ph%0d run%b want=ph5 run0", i, o_v[15:13], o_v[12]);
            end
        end
        check_cnt++;
        if (ld_seen) begin fail_cnt++; $display("FAIL halt_no_pc_ld got=1 want=0"); end
        START  = 1'b0;
        CLEARn = 1'b0;
        #1;
        check_cnt++;
        if (PHASE !== 3'd0) begin fail_cnt++; $display("FAIL halt_clear got=%0d want=0", PHASE); end
        CLEARn = 1'b1;
        model_reset();
    endtask

    task automatic test_step();
        int inc_cnt = 0;
        do_clear();
        STEP  = 1'b1;
        START = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(o_v, e_v);
            check_cnt++;
            if (o_v !== e_v) begin fail_cnt++; $display("FAIL step_model i=%0d got=%h want=%h", i, o_v, e_v); end
            if (o_v[9]) inc_cnt++;
            if (i >= 6) begin
                check_cnt++;
                if (o_v[15:13] !== 3'd0) begin fail_cnt++; $display("FAIL step_idle i=%0d got=%0d want=0", i, o_v[15:13]); end
            end
        end
        check_cnt++;
        if (inc_cnt != 1) begin fail_cnt++; $display("FAIL step_pc_inc_count got=%0d want=1", inc_cnt); end
        STEP = 1'b0; START = 1'b0;
    endtask

    task automatic test_stop();
        do_clear();
        START = 1'b1;
        cyc(o_v, e_v);
        START = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            STOP = (k == 2);
            cyc(o_v, e_v);
            check_cnt++;
            if (o_v !== e_v) begin fail_cnt++; $display("FAIL stop_model k=%0d got=%h want=%h", k, o_v, e_v); end
            if (k >= 6) begin
                check_cnt++;
                if (o_v[15:13] !== 3'd0) begin fail_cnt++; $display("FAIL stop_idle k=%0d got=%0d want=0", k, o_v[15:13]); end
            end
        end
        STOP  = 1'b1;
        START = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(o_v, e_v);
            check_cnt++;
            if (o_v[15:13] !== 3'd0 || o_v !== e_v) begin
                fail_cnt++;
                $display("FAIL stop_start_blocked i=%0d got=%h want=%h", i, o_v, e_v);
            end
        end
        STOP = 1'b0; START = 1'b0;
    endtask

    task automatic test_clear_mid_exec();
        do_clear();
        START = 1'b1;
        cyc(o_v, e_v);
        START = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc(o_v, e_v);
            check_cnt++;
            if (o_v !== e_v) begin fail_cnt++; $display("FAIL clear_model k=%0d got=%h want=%h", k, o_v, e_v); end
        end
        JMP_REQ = 1'b1; JMP_ADDR = 8'h3C;
        #1;
        check_cnt++;
        if (PC_LD !== 1'b1) begin fail_cnt++; $display("FAIL clear_pre_ld got=%b want=1", PC_LD); end
        #2;
        CLEARn = 1'b0;
        #1;
        check_cnt++;
        if (obs_vec() !== 16'h0000) begin fail_cnt++; $display("FAIL clear_immediate got=%h want=0000", obs_vec()); end
        @(posedge clk); #1;
        check_cnt++;
        if (obs_vec() !== 16'h0000) begin fail_cnt++; $display("FAIL clear_after_edge got=%h want=0000", obs_vec()); end
        CLEARn = 1'b1;
        model_reset();
        JMP_REQ = 1'b0;
        cyc(o_v, e_v);
        check_cnt++;
        if (o_v !== e_v) begin fail_cnt++; $display("FAIL clear_idle got=%h want=%h", o_v, e_v); end
    endtask

    task automatic test_random();
        do_clear();
        for (int n = 0; n < 400; n++) begin
            START    = ($urandom_range(0, 3) == 0);
            STOP     = ($urandom_range(0, 15) == 0);
            STEP     = ($urandom_range(0, 3) == 0);
            HALT_REQ = ($urandom_range(0, 19) == 0);
            JMP_REQ  = ($urandom_range(0, 1) == 1);
            JMP_ADDR = 8'($urandom);
            if (m_mode == 2 && $urandom_range(0, 3) == 0) do_clear();
            cyc(o_v, e_v);
            check_cnt++;
            if (o_v !== e_v) begin fail_cnt++; $display("FAIL random n=%0d got=%h want=%h", n, o_v, e_v); end
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_run();
        test_jump();
        test_halt();
        test_step();
        test_stop();
        test_clear_mid_exec();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
`default_nettype wire
